axil_addr_router: RTL and testbench
===================================

# axil_addr_router

Parametrised AXI-Lite address router that connects one upstream manager (the core's load/store port) to `NUM_TGT` downstream targets selected by a base/mask address map. It supports multiple outstanding transactions per direction to the same target, true W-channel routing and a built-in decode-error responder for unmapped addresses. It sits between the core memory port and the cache, UART and future peripheral slaves.

## Interface
- `NUM_TGT`, 2: number of downstream targets (1–8).
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; strobe width is `DATA_W/8`.
- `MAX_OUTSTANDING`, 4: maximum in-flight transactions per direction (1–15).
- `TGT_BASE`, {64'h0, 64'hFFFF_FFFF_FFFF_F000}: packed `[NUM_TGT][ADDR_W]` base addresses; index 0 is the rightmost entry (UART).
- `TGT_MASK`, {64'h0, 64'hFFFF_FFFF_FFFF_F000}: packed `[NUM_TGT][ADDR_W]` masks; index 1 is cache, catch-all.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `read` axil_interface_if.rd_slv: upstream read channel (AR, R with `rresp`).
- `write` axil_interface_if.wr_slv: upstream write channel (AW, W, B with `bresp`).
- `tgt_read[NUM_TGT]` axil_interface_if.rd_mst: downstream read channels.
- `tgt_write[NUM_TGT]` axil_interface_if.wr_mst: downstream write channels.

## Operation
- Decode: target `i` hits when `(addr & TGT_MASK[i]) == TGT_BASE[i]`. The lowest hitting index wins. No hit selects the internal error slot `ERR = NUM_TGT`.
- Per direction, registers: `cnt` (0..MAX_OUTSTANDING) and `sel` (target index or ERR).
- Read accept condition: `arvalid && (cnt==0 || (tgt==sel && sel!=ERR && cnt<MAX_OUTSTANDING))`, combined with the selected target's `arready` for real targets.
  - A request to a different target waits until `cnt==0`. This preserves response ordering.
- AR forwarding: `tgt_read[tgt].arvalid` asserts only when the accept condition (excluding arready) holds. All other targets see `arvalid=0` and `araddr=0`.
- R mux: `read.rvalid/rdata/rresp` come from `tgt_read[sel]`. `rready` goes only to `tgt_read[sel]`; other targets see 0.
- Read counter: `cnt` increments on an AR handshake and decrements on an R handshake. Both in the same cycle leaves it unchanged. `sel` loads on an AR handshake.
- Read ERR: AR is accepted internally (arready=1) only when `cnt==0`. The next cycle `rvalid=1`, `rdata=0`, `rresp=2'b11`, held until `rready`.
- Write AW path: same accept and forward rules as read, using `write.aw*`, `cnt_w` and `sel_w`.
- W routing: `wpend` counts AWs accepted minus Ws accepted (0..MAX_OUTSTANDING).
  - When `wpend>0`: W is forwarded to `tgt_write[sel_w]`, with `wvalid/wdata/wstrb` passed through and `wready` returned.
  - When `wpend==0`: `write.wready=0` and all targets see `wvalid=0`. W arriving before AW stalls.
  - W forwarding also applies in the cycle AW is accepted when `wpend==0`: W is accepted in the same cycle if the target is ready.
- Write ERR: W is sunk internally (`wready=1` while `wpend>0`). `bvalid=1`, `bresp=2'b11` in the cycle after the W handshake, held until `bready`.
- B mux: from `tgt_write[sel_w]`. `bready` goes only to `sel_w`. `cnt_w` decrements on a B handshake.

## Timing
- AR/AW/W/R/B forwarding to real targets is combinational, adding zero cycles.
- ERR responses arrive one cycle after the AR handshake (read) or the W handshake (write).
- Reset values: `cnt`, `cnt_w`, `wpend` = 0; `sel`, `sel_w` = 0; ERR valid flags = 0.
  - While `rst` is high, all upstream readies and valids are 0 and all downstream valids are 0.
- Reset mid-transaction abandons all in-flight state. Downstream targets share `rst`.
- `cnt==MAX_OUTSTANDING` deasserts arready/awready even for a matching target. A simultaneous response handshake does not free the slot in that cycle; the slot is usable the next cycle.
- Upstream valid/data hold-until-ready is required of the manager and is not checked.

## Test plan
- Read at `64'hFFFF_FFFF_FFFF_F010` -> only `tgt_read[0].arvalid=1`, same cycle. `rdata`=UART value returned with `rresp=0`.
- Four back-to-back reads to `0x1000..0x1018` with cache `rready`-delayed responses -> all four accepted, cnt reaches 4, fifth stalls (`arready=0`) until first R handshake.
- Read to cache while one cache read outstanding, then read to UART -> UART AR held (`arready=0`) until cnt returns to 0, then forwarded.
- With `TGT_MASK[1]=64'hFFFF_0000_0000_0000`, `TGT_BASE[1]=0`, read at `64'h1234_0000_0000_0000` -> arready=1, next cycle rvalid=1, rdata=0, rresp=2'b11. Write to the same address with W 2 cycles later -> bresp=2'b11 one cycle after W handshake.
- W presented 3 cycles before AW to cache -> wready=0 until AW handshake, W accepted the same cycle as AW, `tgt_write[1]` sees wdata/wstrb unchanged, bvalid relayed.
- Assert `rst` with 2 reads outstanding -> next cycle cnt=0, all valids 0; the first post-reset read to UART is accepted immediately.

Source files
------------

// File: rtl/axil_addr_router.sv
// ============================================================================
// Module   : axil_addr_router
// Brief    : AXI-Lite router, one manager to NUM_TGT targets via base/mask map,
//            with an internal decode-error responder for unmapped addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_addr_router #(
  parameter int NUM_TGT         = 2,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_BASE = {64'h0, 64'hFFFF_FFFF_FFFF_F000},
  parameter logic [NUM_TGT-1:0][ADDR_W-1:0] TGT_MASK = {64'h0, 64'hFFFF_FFFF_FFFF_F000}
) (
  input  logic                                clk,
  input  logic                                rst,
  // upstream read
  input  logic [ADDR_W-1:0]                   i_read_araddr,
  input  logic                                i_read_arvalid,
  output logic                                o_read_arready,
  output logic [DATA_W-1:0]                   o_read_rdata,
  output logic [1:0]                          o_read_rresp,
  output logic                                o_read_rvalid,
  input  logic                                i_read_rready,
  // upstream write
  input  logic [ADDR_W-1:0]                   i_write_awaddr,
  input  logic                                i_write_awvalid,
  output logic                                o_write_awready,
  input  logic [DATA_W-1:0]                   i_write_wdata,
  input  logic [DATA_W/8-1:0]                 i_write_wstrb,
  input  logic                                i_write_wvalid,
  output logic                                o_write_wready,
  output logic [1:0]                          o_write_bresp,
  output logic                                o_write_bvalid,
  input  logic                                i_write_bready,
  // downstream read
  output logic [NUM_TGT-1:0][ADDR_W-1:0]      o_tgt_araddr,
  output logic [NUM_TGT-1:0]                  o_tgt_arvalid,
  input  logic [NUM_TGT-1:0]                  i_tgt_arready,
  input  logic [NUM_TGT-1:0][DATA_W-1:0]      i_tgt_rdata,
  input  logic [NUM_TGT-1:0][1:0]             i_tgt_rresp,
  input  logic [NUM_TGT-1:0]                  i_tgt_rvalid,
  output logic [NUM_TGT-1:0]                  o_tgt_rready,
  // downstream write
  output logic [NUM_TGT-1:0][ADDR_W-1:0]      o_tgt_awaddr,
  output logic [NUM_TGT-1:0]                  o_tgt_awvalid,
  input  logic [NUM_TGT-1:0]                  i_tgt_awready,
  output logic [NUM_TGT-1:0][DATA_W-1:0]      o_tgt_wdata,
  output logic [NUM_TGT-1:0][DATA_W/8-1:0]    o_tgt_wstrb,
  output logic [NUM_TGT-1:0]                  o_tgt_wvalid,
  input  logic [NUM_TGT-1:0]                  i_tgt_wready,
  input  logic [NUM_TGT-1:0][1:0]             i_tgt_bresp,
  input  logic [NUM_TGT-1:0]                  i_tgt_bvalid,
  output logic [NUM_TGT-1:0]                  o_tgt_bready
);

  localparam int c_SEL_W = $clog2(NUM_TGT + 1);
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_SEL_W-1:0] c_ERR = c_SEL_W'(NUM_TGT);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0]         c_DECERR = 2'b11;

  // Lowest hitting index wins; no hit selects the internal error slot.
  function automatic logic [c_SEL_W-1:0] f_decode(input logic [ADDR_W-1:0] addr);
    logic [c_SEL_W-1:0] v_sel;
    v_sel = c_ERR;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((addr & TGT_MASK[i]) == TGT_BASE[i]) v_sel = c_SEL_W'(i);
    end
    return v_sel;
  endfunction

  logic [c_CNT_W-1:0] r_rd_cnt, r_wr_cnt, r_wpend;
  logic [c_SEL_W-1:0] r_rd_sel, r_wr_sel;
  logic               r_rd_err_valid, r_wr_err_valid;

  logic [c_SEL_W-1:0] w_ar_tgt, w_aw_tgt, w_w_tgt;
  logic               w_ar_ok, w_aw_ok, w_ar_tgt_rdy, w_aw_tgt_rdy, w_w_tgt_rdy;
  logic               w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_w_en;

  assign w_ar_tgt = f_decode(i_read_araddr);
  assign w_aw_tgt = f_decode(i_write_awaddr);

  // A new target is only admitted once everything in flight has drained,
  // which keeps responses in request order without any reorder buffering.
  assign w_ar_ok = i_read_arvalid && !rst &&
                   ((r_rd_cnt == '0) ||
                    (w_ar_tgt == r_rd_sel && r_rd_sel != c_ERR && r_rd_cnt < c_MAX));
  assign w_aw_ok = i_write_awvalid && !rst &&
                   ((r_wr_cnt == '0) ||
                    (w_aw_tgt == r_wr_sel && r_wr_sel != c_ERR && r_wr_cnt < c_MAX));

  always_comb begin
    w_ar_tgt_rdy  = 1'b1;
    o_tgt_arvalid = '0;
    o_tgt_araddr  = '0;
    w_aw_tgt_rdy  = 1'b1;
    o_tgt_awvalid = '0;
    o_tgt_awaddr  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (w_ar_tgt == c_SEL_W'(i)) begin
        w_ar_tgt_rdy     = i_tgt_arready[i];
        o_tgt_arvalid[i] = w_ar_ok;
        o_tgt_araddr[i]  = w_ar_ok ? i_read_araddr : '0;
      end
      if (w_aw_tgt == c_SEL_W'(i)) begin
        w_aw_tgt_rdy     = i_tgt_awready[i];
        o_tgt_awvalid[i] = w_aw_ok;
        o_tgt_awaddr[i]  = w_aw_ok ? i_write_awaddr : '0;
      end
    end
  end

  assign o_read_arready  = w_ar_ok && w_ar_tgt_rdy;
  assign o_write_awready = w_aw_ok && w_aw_tgt_rdy;
  assign w_ar_hs         = o_read_arready;
  assign w_aw_hs         = o_write_awready;

  always_comb begin
    o_read_rvalid = r_rd_err_valid;
    o_read_rdata  = '0;
    o_read_rresp  = c_DECERR;
    o_tgt_rready  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (r_rd_sel == c_SEL_W'(i)) begin
        o_read_rvalid   = i_tgt_rvalid[i];
        o_read_rdata    = i_tgt_rdata[i];
        o_read_rresp    = i_tgt_rresp[i];
        o_tgt_rready[i] = i_read_rready;
      end
    end
    if (rst) o_read_rvalid = 1'b0;
  end

  assign w_r_hs = o_read_rvalid && i_read_rready;

  // W may ride along with its own AW when nothing is pending yet; sel_w is
  // not loaded until the following edge, so route by the live decode then.
  assign w_w_en  = (r_wpend != '0) || w_aw_hs;
  assign w_w_tgt = (r_wpend != '0) ? r_wr_sel : w_aw_tgt;

  always_comb begin
    w_w_tgt_rdy  = 1'b1;
    o_tgt_wvalid = '0;
    o_tgt_wdata  = '0;
    o_tgt_wstrb  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (w_w_tgt == c_SEL_W'(i)) begin
        w_w_tgt_rdy     = i_tgt_wready[i];
        o_tgt_wvalid[i] = w_w_en && i_write_wvalid;
        o_tgt_wdata[i]  = i_write_wdata;
        o_tgt_wstrb[i]  = i_write_wstrb;
      end
    end
  end

  assign o_write_wready = w_w_en && w_w_tgt_rdy;
  assign w_w_hs         = o_write_wready && i_write_wvalid;

  always_comb begin
    o_write_bvalid = r_wr_err_valid;
    o_write_bresp  = c_DECERR;
    o_tgt_bready   = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (r_wr_sel == c_SEL_W'(i)) begin
        o_write_bvalid  = i_tgt_bvalid[i];
        o_write_bresp   = i_tgt_bresp[i];
        o_tgt_bready[i] = i_write_bready;
      end
    end
    if (rst) o_write_bvalid = 1'b0;
  end

  assign w_b_hs = o_write_bvalid && i_write_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt       <= '0;
      r_rd_sel       <= '0;
      r_rd_err_valid <= 1'b0;
    end else begin
      case ({w_ar_hs, w_r_hs})
        2'b10:   r_rd_cnt <= r_rd_cnt + c_CNT_W'(1);
        2'b01:   r_rd_cnt <= r_rd_cnt - c_CNT_W'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      if (w_ar_hs) r_rd_sel <= w_ar_tgt;
      if (w_ar_hs && w_ar_tgt == c_ERR)      r_rd_err_valid <= 1'b1;
      else if (w_r_hs && r_rd_sel == c_ERR)  r_rd_err_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt       <= '0;
      r_wpend        <= '0;
      r_wr_sel       <= '0;
      r_wr_err_valid <= 1'b0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_wr_cnt <= r_wr_cnt + c_CNT_W'(1);
        2'b01:   r_wr_cnt <= r_wr_cnt - c_CNT_W'(1);
        default: r_wr_cnt <= r_wr_cnt;
      endcase
      case ({w_aw_hs, w_w_hs})
        2'b10:   r_wpend <= r_wpend + c_CNT_W'(1);
        2'b01:   r_wpend <= r_wpend - c_CNT_W'(1);
        default: r_wpend <= r_wpend;
      endcase
      if (w_aw_hs) r_wr_sel <= w_aw_tgt;
      if (w_w_hs && w_w_tgt == c_ERR)        r_wr_err_valid <= 1'b1;
      else if (w_b_hs && r_wr_sel == c_ERR)  r_wr_err_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_addr_router.sv
// ============================================================================
// Module   : tb_axil_addr_router
// Brief    : Scoreboard bench for axil_addr_router with UART and cache models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_addr_router;

  localparam logic [63:0] c_M0 = 64'hFFFF_FFFF_FFFF_F000;
  localparam logic [63:0] c_B0 = 64'hFFFF_FFFF_FFFF_F000;
  localparam logic [63:0] c_M1 = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] c_B1 = 64'h0;
  localparam logic [63:0] c_ERR_ADDR = 64'h1234_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [7:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;

  logic [1:0][63:0] tgt_araddr, tgt_rdata, tgt_awaddr, tgt_wdata;
  logic [1:0][7:0]  tgt_wstrb;
  logic [1:0][1:0]  tgt_rresp, tgt_bresp;
  logic [1:0] tgt_arvalid, tgt_arready, tgt_rvalid, tgt_rready;
  logic [1:0] tgt_awvalid, tgt_awready, tgt_wvalid, tgt_wready, tgt_bvalid, tgt_bready;

  axil_addr_router #(
    .NUM_TGT(2), .ADDR_W(64), .DATA_W(64), .MAX_OUTSTANDING(4),
    .TGT_BASE({c_B1, c_B0}), .TGT_MASK({c_M1, c_M0})
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_read_araddr(araddr), .i_read_arvalid(arvalid), .o_read_arready(arready),
    .o_read_rdata(rdata), .o_read_rresp(rresp), .o_read_rvalid(rvalid), .i_read_rready(rready),
    .i_write_awaddr(awaddr), .i_write_awvalid(awvalid), .o_write_awready(awready),
    .i_write_wdata(wdata), .i_write_wstrb(wstrb), .i_write_wvalid(wvalid), .o_write_wready(wready),
    .o_write_bresp(bresp), .o_write_bvalid(bvalid), .i_write_bready(bready),
    .o_tgt_araddr(tgt_araddr), .o_tgt_arvalid(tgt_arvalid), .i_tgt_arready(tgt_arready),
    .i_tgt_rdata(tgt_rdata), .i_tgt_rresp(tgt_rresp), .i_tgt_rvalid(tgt_rvalid), .o_tgt_rready(tgt_rready),
    .o_tgt_awaddr(tgt_awaddr), .o_tgt_awvalid(tgt_awvalid), .i_tgt_awready(tgt_awready),
    .o_tgt_wdata(tgt_wdata), .o_tgt_wstrb(tgt_wstrb), .o_tgt_wvalid(tgt_wvalid), .i_tgt_wready(tgt_wready),
    .i_tgt_bresp(tgt_bresp), .i_tgt_bvalid(tgt_bvalid), .o_tgt_bready(tgt_bready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent address map: 0 = UART, 1 = cache, 2 = unmapped.
  function automatic int f_dec(input logic [63:0] a);
    if ((a & c_M0) == c_B0) return 0;
    if ((a & c_M1) == c_B1) return 1;
    return 2;
  endfunction

  function automatic logic [63:0] f_tgt_data(input int t, input logic [63:0] a);
    return (t == 0) ? (a ^ 64'h0000_0000_5AA5_0000) : (a ^ 64'hC0DE_0000_0000_0000);
  endfunction

  logic [63:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];
  logic [63:0] rq0[$], rq1[$];
  int          awc[2], wc[2], bc[2];
  logic [1:0]  f_ar, f_r, f_aw, f_w, f_b;
  logic [63:0] f_a0, f_a1;

  // Target models plus upstream scoreboard; handshakes sampled mid-cycle.
  initial begin : tgt_model
    tgt_arready = 2'b11; tgt_awready = 2'b11; tgt_wready = 2'b11;
    tgt_rvalid = '0; tgt_rdata = '0; tgt_rresp = '0;
    tgt_bvalid = '0; tgt_bresp = '0;
    for (int t = 0; t < 2; t++) begin awc[t] = 0; wc[t] = 0; bc[t] = 0; end
    forever begin
      @(negedge clk);
      f_ar = '0; f_r = '0; f_aw = '0; f_w = '0; f_b = '0;
      if (rst) begin
        exp_rdata_q.delete(); exp_rresp_q.delete(); exp_bresp_q.delete();
        rq0.delete(); rq1.delete();
        for (int t = 0; t < 2; t++) begin awc[t] = 0; wc[t] = 0; bc[t] = 0; end
      end else begin
        f_ar = tgt_arvalid & tgt_arready;
        f_r  = tgt_rvalid & tgt_rready;
        f_aw = tgt_awvalid & tgt_awready;
        f_w  = tgt_wvalid & tgt_wready;
        f_b  = tgt_bvalid & tgt_bready;
        f_a0 = tgt_araddr[0];
        f_a1 = tgt_araddr[1];
        if (rvalid && rready) begin
          chk("r_expected", 64'(exp_rdata_q.size() > 0), 64'd1);
          if (exp_rdata_q.size() > 0) begin
            chk("rdata", rdata, exp_rdata_q.pop_front());
            chk("rresp", 64'(rresp), 64'(exp_rresp_q.pop_front()));
          end
        end
        if (bvalid && bready) begin
          chk("b_expected", 64'(exp_bresp_q.size() > 0), 64'd1);
          if (exp_bresp_q.size() > 0) chk("bresp", 64'(bresp), 64'(exp_bresp_q.pop_front()));
        end
        if (arvalid && arready) begin
          exp_rdata_q.push_back(f_dec(araddr) == 2 ? 64'h0 : f_tgt_data(f_dec(araddr), araddr));
          exp_rresp_q.push_back(f_dec(araddr) == 2 ? 2'b11 : 2'b00);
        end
        if (awvalid && awready) exp_bresp_q.push_back(f_dec(awaddr) == 2 ? 2'b11 : 2'b00);
      end
      @(posedge clk); #1;
      if (!rst) begin
        if (f_r[0]) void'(rq0.pop_front());
        if (f_r[1]) void'(rq1.pop_front());
        if (f_ar[0]) rq0.push_back(f_tgt_data(0, f_a0));
        if (f_ar[1]) rq1.push_back(f_tgt_data(1, f_a1));
        for (int t = 0; t < 2; t++) begin
          if (f_aw[t]) awc[t]++;
          if (f_w[t])  wc[t]++;
          if (f_b[t])  bc[t]--;
          if (awc[t] > 0 && wc[t] > 0) begin awc[t]--; wc[t]--; bc[t]++; end
        end
      end
      tgt_rvalid[0] = (rq0.size() != 0);
      tgt_rdata[0]  = (rq0.size() != 0) ? rq0[0] : 64'h0;
      tgt_rvalid[1] = (rq1.size() != 0);
      tgt_rdata[1]  = (rq1.size() != 0) ? rq1[0] : 64'h0;
      for (int t = 0; t < 2; t++) tgt_bvalid[t] = (bc[t] > 0);
    end
  end

  task automatic ar_send(input logic [63:0] a, output int waited);
    araddr = a; arvalid = 1'b1; waited = 0;
    @(negedge clk);
    while (!arready && waited < 30) begin waited++; @(negedge clk); end
    chk("ar_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; araddr = '0;
  endtask

  task automatic aw_send(input logic [63:0] a, output int waited);
    awaddr = a; awvalid = 1'b1; waited = 0;
    @(negedge clk);
    while (!awready && waited < 30) begin waited++; @(negedge clk); end
    chk("aw_accept", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; awaddr = '0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, output int waited);
    wdata = d; wstrb = s; wvalid = 1'b1; waited = 0;
    @(negedge clk);
    while (!wready && waited < 30) begin waited++; @(negedge clk); end
    chk("w_accept", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && (exp_rdata_q.size() != 0 || exp_bresp_q.size() != 0); k++)
      @(posedge clk);
    #1;
    chk("drain_r", 64'(exp_rdata_q.size()), 64'd0);
    chk("drain_b", 64'(exp_bresp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int w2;
    rst = 1'b1; rready = 1'b1; bready = 1'b1;
    araddr = 64'hFFFF_FFFF_FFFF_F000; arvalid = 1'b1;
    awaddr = 64'h1000; awvalid = 1'b1;
    wdata = '0; wstrb = '0; wvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_tgt_valids", 64'({tgt_arvalid, tgt_awvalid, tgt_wvalid}), 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; araddr = '0; awaddr = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rvalid", 64'(rvalid), 64'd0);
    chk("idle_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1;

    // UART read: forwarded only to target 0 in the same cycle
    fork
      ar_send(64'hFFFF_FFFF_FFFF_F010, w);
      begin
        @(negedge clk);
        chk("uart_arvalid", 64'(tgt_arvalid), 64'd1);
        chk("uart_araddr0", tgt_araddr[0], 64'hFFFF_FFFF_FFFF_F010);
        chk("uart_araddr1", tgt_araddr[1], 64'h0);
      end
    join
    chk("uart_wait", 64'(w), 64'd0);
    wait_drain();

    // Four outstanding cache reads, fifth stalls until a slot frees
    rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ar_send(64'h1000 + 64'(8 * k), w);
      chk("burst_wait", 64'(w), 64'd0);
    end
    fork
      ar_send(64'h1020, w);
      begin repeat (3) @(posedge clk); #1; rready = 1'b1; end
    join
    chk("fifth_wait", 64'(w), 64'd4);
    wait_drain();

    // Cache read outstanding, then UART read held until drained
    rready = 1'b0;
    ar_send(64'h2000, w);
    fork
      ar_send(64'hFFFF_FFFF_FFFF_F020, w);
      begin
        @(negedge clk);
        chk("uart_ar_held", 64'(tgt_arvalid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("uart_ar_fwd", 64'(tgt_arvalid), 64'd1);
      end
    join
    chk("switch_wait", 64'(w), 64'd3);
    wait_drain();

    // Unmapped read: decode error one cycle after AR, held until rready
    rready = 1'b0;
    ar_send(c_ERR_ADDR, w);
    chk("err_ar_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("err_rvalid", 64'(rvalid), 64'd1);
    chk("err_rdata", rdata, 64'h0);
    chk("err_rresp", 64'(rresp), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_rvalid_hold", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    rready = 1'b1;
    wait_drain();

    // Unmapped write, W two cycles after AW
    aw_send(c_ERR_ADDR, w);
    chk("err_aw_wait", 64'(w), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("err_b_early", 64'(bvalid), 64'd0);
      @(posedge clk); #1;
    end
    w_send(64'hDEAD_BEEF_0000_0001, 8'hFF, w2);
    chk("err_w_wait", 64'(w2), 64'd0);
    @(negedge clk);
    chk("err_bvalid", 64'(bvalid), 64'd1);
    chk("err_bresp", 64'(bresp), 64'd3);
    wait_drain();

    // W presented before AW to the cache
    wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'h5A; wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("w_stall", 64'({wready, tgt_wvalid}), 64'd0);
      @(posedge clk); #1;
    end
    awaddr = 64'h3000; awvalid = 1'b1;
    @(negedge clk);
    chk("w_aw_awready", 64'(awready), 64'd1);
    chk("w_aw_wready", 64'(wready), 64'd1);
    chk("w_aw_tgt_wvalid", 64'(tgt_wvalid), 64'd2);
    chk("w_aw_wdata", tgt_wdata[1], 64'h0123_4567_89AB_CDEF);
    chk("w_aw_wstrb", 64'(tgt_wstrb[1]), 64'h5A);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = '0;
    wait_drain();

    // Reset with two reads outstanding
    rready = 1'b0;
    ar_send(64'h4000, w);
    ar_send(64'h4008, w);
    @(posedge clk); #2;
    rst = 1'b1;
    araddr = 64'hFFFF_FFFF_FFFF_F030; arvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_arready", 64'(arready), 64'd0);
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_tgt_arvalid", 64'(tgt_arvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b1;
    ar_send(64'hFFFF_FFFF_FFFF_F030, w);
    chk("post_rst_wait", 64'(w), 64'd0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
